// File: rtl/error_sig_tx_v3.sv
// Soft-error signal transmitter: edge-detects dual-redundant error flags, arbitrates by lowest ID
// and serialises framed, parity-protected words. Optional heartbeat: ERRSIG_HEARTBEAT_EN.
module error_sig_tx_v3 #(
  parameter int unsigned ERRSIG_ID_num = 7,
  parameter int unsigned BIT_CYCLES    = 4,
  parameter int unsigned GAP_BITS      = 2,
  parameter int unsigned HB_PERIOD     = 1000000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [ERRSIG_ID_num-1:0] error_A,
  input  logic [ERRSIG_ID_num-1:0] error_B,
  output logic                     output_err_sig,
  output logic                     debug_sig,
  output logic                     busy,
  output logic [ERRSIG_ID_num-1:0] pending,
  output logic [15:0]              frame_count,
  output logic [15:0]              drop_count
);

  localparam int unsigned ID_W     = $clog2(ERRSIG_ID_num + 1);
  localparam int unsigned F        = ID_W + 5;
  localparam int unsigned GAP_CLKS = GAP_BITS * BIT_CYCLES;
  localparam int unsigned CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned IW       = $clog2(F);
  localparam int unsigned GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  if (ERRSIG_ID_num < 1 || BIT_CYCLES < 1 || HB_PERIOD < 1) begin : g_bad_param
    $error("error_sig_tx_v3: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e                   state_q, state_d;
  logic [ERRSIG_ID_num-1:0] prev_a_q, prev_b_q, pend_a_q, pend_b_q, pend_a_d, pend_b_d;
  logic [ERRSIG_ID_num-1:0] rise_a, rise_b, drop_a, drop_b, first, clr, pend_any;
  logic [F-1:0]             shreg_q, shreg_d, frame;
  logic [CW-1:0]            cyc_q, cyc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic                     busy_q, busy_d, dbg_q;
  logic [15:0]              frame_count_q, drop_count_q, drop_count_d;
  logic [16:0]              drop_sum;
  logic [ID_W-1:0]          sel, id;
  logic [1:0]               typ_sel, typ;
  logic                     err_req, hb_req, frame_done, load;

`ifdef ERRSIG_HEARTBEAT_EN
  localparam int unsigned HW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  logic [HW-1:0] hb_cnt_q;
  logic          hb_pend_q, hb_expire;

  assign hb_expire = (hb_cnt_q == HW'(HB_PERIOD - 1));
  assign hb_req    = hb_pend_q;

  // An expiry on the load edge keeps hb_pend set, mirroring the error set-wins rule.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hb_cnt_q  <= '0;
      hb_pend_q <= 1'b0;
    end else begin
      hb_cnt_q  <= hb_expire ? '0 : hb_cnt_q + 1'b1;
      hb_pend_q <= hb_expire | (hb_pend_q & ~(load & ~err_req));
    end
  end
`else
  assign hb_req = 1'b0;
`endif

  assign rise_a   = error_A & ~prev_a_q;
  assign rise_b   = error_B & ~prev_b_q;
  assign pend_any = pend_a_q | pend_b_q;
  assign err_req  = |pend_any;

  // Lowest pending ID wins; heartbeat only when no error is pending.
  always_comb begin
    sel     = '0;
    first   = '0;
    typ_sel = 2'b00;
    for (int i = int'(ERRSIG_ID_num) - 1; i >= 0; i--) begin
      if (pend_any[i]) begin
        sel      = ID_W'(i);
        first    = '0;
        first[i] = 1'b1;
        typ_sel  = {pend_a_q[i], pend_b_q[i]};
      end
    end
    id    = err_req ? sel : '1;
    typ   = err_req ? typ_sel : 2'b00;
    frame = {1'b1, id, typ, ^{id, typ}, 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    frame_done = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      StIdle: ;
      StShift: begin
        if (cyc_q == CW'(BIT_CYCLES - 1)) begin
          cyc_d   = '0;
          shreg_d = shreg_q << 1;
          if (idx_q == IW'(F - 1)) begin
            idx_d = '0;
            if (GAP_CLKS == 0) frame_done = 1'b1;
            else               state_d    = StGap;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GW'(GAP_CLKS - 1)) begin
          gap_d      = '0;
          frame_done = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // The last gap cycle doubles as the idle decision cycle so frames pack back-to-back.
    if (state_q == StIdle || frame_done) begin
      if (err_req || hb_req) begin
        load    = 1'b1;
        shreg_d = frame;
        state_d = StShift;
        busy_d  = 1'b1;
        cyc_d   = '0;
        idx_d   = '0;
        gap_d   = '0;
      end else begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    end
  end

  always_comb begin
    clr      = (load && err_req) ? first : '0;
    drop_a   = rise_a & pend_a_q & ~clr;
    drop_b   = rise_b & pend_b_q & ~clr;
    pend_a_d = (pend_a_q & ~clr) | rise_a;
    pend_b_d = (pend_b_q & ~clr) | rise_b;
    drop_sum = {1'b0, drop_count_q};
    for (int i = 0; i < int'(ERRSIG_ID_num); i++) begin
      drop_sum = drop_sum + 17'(drop_a[i]) + 17'(drop_b[i]);
    end
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      prev_a_q      <= '0;
      prev_b_q      <= '0;
      pend_a_q      <= '0;
      pend_b_q      <= '0;
      shreg_q       <= '0;
      cyc_q         <= '0;
      idx_q         <= '0;
      gap_q         <= '0;
      busy_q        <= 1'b0;
      dbg_q         <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      prev_a_q      <= error_A;
      prev_b_q      <= error_B;
      pend_a_q      <= pend_a_d;
      pend_b_q      <= pend_b_d;
      shreg_q       <= shreg_d;
      cyc_q         <= cyc_d;
      idx_q         <= idx_d;
      gap_q         <= gap_d;
      busy_q        <= busy_d;
      dbg_q         <= load;
      frame_count_q <= load ? frame_count_q + 16'd1 : frame_count_q;
      drop_count_q  <= drop_count_d;
    end
  end

  assign output_err_sig = shreg_q[F-1];
  assign debug_sig      = dbg_q;
  assign busy           = busy_q;
  assign pending        = pend_any;
  assign frame_count    = frame_count_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_error_sig_tx_v3.sv
// Randomised bench for error_sig_tx_v3 against a waveform-queue reference model.
module tb_error_sig_tx_v3;
  localparam int N   = 7;
  localparam int BC  = 4;
  localparam int GB  = 2;
  localparam int IDW = $clog2(N + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ea, eb;
  logic         out_sig, dbg, bsy;
  logic [N-1:0] pend;
  logic [15:0]  fcnt, dcnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0] m_prev_a, m_prev_b, m_pa, m_pb;
  logic [15:0]  m_frames, m_drops;
  logic         m_out, m_busy, m_dbg;
  bit           wave[$];

  always #5 clk = ~clk;

  error_sig_tx_v3 #(
    .ERRSIG_ID_num(N),
    .BIT_CYCLES   (BC),
    .GAP_BITS     (GB),
    .HB_PERIOD    (100)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .error_A       (ea),
    .error_B       (eb),
    .output_err_sig(out_sig),
    .debug_sig     (dbg),
    .busy          (bsy),
    .pending       (pend),
    .frame_count   (fcnt),
    .drop_count    (dcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Applies the behavioural rules for one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    logic [N-1:0] ra, rb;
    int           sel;
    bit           ld;
    bit           bits[$];
    int           ones;
    if (rst) begin
      m_prev_a = '0; m_prev_b = '0; m_pa = '0; m_pb = '0;
      m_frames = '0; m_drops = '0;
      m_out = 0; m_busy = 0; m_dbg = 0;
      wave.delete();
      return;
    end
    ra  = ea & ~m_prev_a;
    rb  = eb & ~m_prev_b;
    sel = -1;
    for (int i = 0; i < N; i++) if (sel < 0 && (m_pa[i] || m_pb[i])) sel = i;
    ld = (wave.size() == 0) && (sel >= 0);
    if (ld) begin
      ones = 0;
      bits.push_back(1'b1);
      for (int b = IDW - 1; b >= 0; b--) begin
        bits.push_back(bit'((sel >> b) & 1));
        ones += (sel >> b) & 1;
      end
      bits.push_back(m_pa[sel]);
      bits.push_back(m_pb[sel]);
      ones += int'(m_pa[sel]) + int'(m_pb[sel]);
      bits.push_back(bit'(ones % 2));
      bits.push_back(1'b0);
      foreach (bits[k]) for (int c = 0; c < BC; c++) wave.push_back(bits[k]);
      for (int c = 0; c < GB * BC; c++) wave.push_back(1'b0);
      m_frames = m_frames + 16'd1;
    end
    for (int i = 0; i < N; i++) begin
      bit cl = ld && (i == sel);
      if (ra[i] && m_pa[i] && !cl && m_drops != 16'hFFFF) m_drops++;
      if (rb[i] && m_pb[i] && !cl && m_drops != 16'hFFFF) m_drops++;
      m_pa[i] = (m_pa[i] && !cl) || ra[i];
      m_pb[i] = (m_pb[i] && !cl) || rb[i];
    end
    m_dbg = ld;
    if (wave.size() != 0) begin
      m_out  = wave.pop_front();
      m_busy = 1'b1;
    end else begin
      m_out  = 1'b0;
      m_busy = 1'b0;
    end
    m_prev_a = ea;
    m_prev_b = eb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out", 32'(out_sig), 32'(m_out));
    check("busy", 32'(bsy), 32'(m_busy));
    check("dbg", 32'(dbg), 32'(m_dbg));
    check("pending", 32'(pend), 32'(m_pa | m_pb));
    check("frames", 32'(fcnt), 32'(m_frames));
    check("drops", 32'(dcnt), 32'(m_drops));
  endtask

  function automatic logic [N-1:0] rmask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = ($urandom_range(15) == 0);
    return m;
  endfunction

  initial begin
    logic [7:0] pat;
    rst = 1'b1; ea = '0; eb = '0;
    repeat (3) tick();
    check("rst_frames", 32'(fcnt), 32'd0);
    rst = 1'b0;
    tick();

    // Held level -> one frame 1,010,10,0,0 at 4 clocks per bit, busy for 40 clocks
    ea[2] = 1'b1;
    tick();
    tick();
    pat = 8'b1010_1000;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < BC; c++) begin
        check("t1_bit", 32'(out_sig), 32'(pat[7-b]));
        check("t1_busy", 32'(bsy), 32'd1);
        tick();
      end
    end
    repeat (8) begin
      check("t1_gap", 32'(out_sig), 32'd0);
      check("t1_gapbusy", 32'(bsy), 32'd1);
      tick();
    end
    check("t1_idle", 32'(bsy), 32'd0);
    repeat (80) tick();
    ea = '0;
    repeat (10) tick();
    check("t1_frames", 32'(fcnt), 32'd1);
    check("t1_drops", 32'(dcnt), 32'd0);

    // Simultaneous rises on IDs 1 and 5
    ea[1] = 1'b1; eb[1] = 1'b1; eb[5] = 1'b1;
    tick();
    ea = '0; eb = '0;
    repeat (100) tick();
    check("t2_frames", 32'(fcnt), 32'd3);

    // Double pulse on ID 3 during an ID 0 frame -> one drop
    ea[0] = 1'b1; tick(); ea[0] = 1'b0; tick(); tick();
    ea[3] = 1'b1; tick(); ea[3] = 1'b0; tick();
    ea[3] = 1'b1; tick(); ea[3] = 1'b0;
    repeat (100) tick();
    check("t3_drops", 32'(dcnt), 32'd1);
    check("t3_frames", 32'(fcnt), 32'd5);

    // New rise on ID 4 on its own load edge -> two ID 4 frames, no drop
    ea[4] = 1'b1; tick();
    ea[4] = 1'b0; eb[4] = 1'b1; tick();
    eb[4] = 1'b0;
    repeat (100) tick();
    check("t4_drops", 32'(dcnt), 32'd1);
    check("t4_frames", 32'(fcnt), 32'd7);

    // Reset during bit 3 of a frame
    ea[6] = 1'b1; tick(); ea[6] = 1'b0; tick();
    ea[0] = 1'b1; tick(); ea[0] = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    check("t5_out", 32'(out_sig), 32'd0);
    check("t5_pend", 32'(pend), 32'd0);
    check("t5_frames", 32'(fcnt), 32'd0);
    check("t5_drops", 32'(dcnt), 32'd0);
    rst = 1'b0;
    repeat (60) tick();
    check("t5_quiet", 32'(fcnt), 32'd0);

    // Random traffic with occasional reset
    repeat (4000) begin
      ea  = ea ^ rmask();
      eb  = eb ^ rmask();
      rst = ($urandom_range(999) == 0);
      tick();
    end
    rst = 1'b0; ea = '0; eb = '0;
    repeat (300) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
